// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package mdu_defs;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MTHI  = 3'd4,
    MDU_MTLO  = 3'd5,
    MDU_RSV6  = 3'd6,
    MDU_RSV7  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } mdu_state_e;

  localparam int DEF_MULT_LAT = 5;
  localparam int DEF_DIV_LAT  = 10;
  localparam int CNT_W        = 16;

endpackage

// File: rtl/mdu_calc.sv
// Combinational datapath producing {hi, lo} for MULT/MULTU/DIV/DIVU,
// including signed division overflow and divide-by-zero results.
module mdu_calc
  import mdu_defs::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        is_div_s;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] divisor;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo;
  logic [31:0] rem;

  assign prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
  assign prod_u = {32'd0, src_a} * {32'd0, src_b};

  // Signed division runs on magnitudes so 0x80000000 / -1 wraps cleanly to
  // 0x80000000 instead of relying on native signed-divide overflow.
  assign is_div_s = (op == MDU_DIV);
  assign a_neg    = is_div_s & src_a[31];
  assign b_neg    = is_div_s & src_b[31];
  assign a_mag    = a_neg ? (~src_a + 32'd1) : src_a;
  assign b_mag    = b_neg ? (~src_b + 32'd1) : src_b;
  assign divisor  = (src_b == 32'd0) ? 32'd1 : b_mag;
  assign quo_mag  = a_mag / divisor;
  assign rem_mag  = a_mag % divisor;
  assign quo      = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
  assign rem      = a_neg ? (~rem_mag + 32'd1) : rem_mag;

  always_comb begin
    hi = 32'd0;
    lo = 32'd0;
    case (mdu_op_e'(op))
      MDU_MULT: begin
        hi = prod_s[63:32];
        lo = prod_s[31:0];
      end
      MDU_MULTU: begin
        hi = prod_u[63:32];
        lo = prod_u[31:0];
      end
      MDU_DIV, MDU_DIVU: begin
        if (src_b == 32'd0) begin
          hi = src_a;
          lo = 32'hFFFF_FFFF;
        end else begin
          hi = rem;
          lo = quo;
        end
      end
      default: begin
        hi = 32'd0;
        lo = 32'd0;
      end
    endcase
  end

endmodule

// File: rtl/mdu_hilo.sv
// HI/LO register file with a fixed-latency MDU sequencer. Results are computed
// at accept time, held in pend_hi/pend_lo, and committed after the latency.
module mdu_hilo
  import mdu_defs::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        Start,
  input  logic [2:0]  MDUop,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output mdu_state_e  dbg_state
);

  // Handshake: Start is a single-cycle strobe taken only while Busy=0; any
  // Start seen with Busy=1 is dropped and the controller must stall and retry.

  mdu_state_e       state_q;
  mdu_state_e       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [31:0]      pend_hi;
  logic [31:0]      pend_lo;
  logic [31:0]      calc_hi;
  logic [31:0]      calc_lo;
  logic             accept;
  logic             commit;
  logic             mt_hi;
  logic             mt_lo;
  logic             done_q;

  mdu_calc u_calc (
    .op    (MDUop),
    .src_a (SrcA),
    .src_b (SrcB),
    .hi    (calc_hi),
    .lo    (calc_lo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    mt_hi   = 1'b0;
    mt_lo   = 1'b0;
    case (state_q)
      IDLE: begin
        if (Start) begin
          case (mdu_op_e'(MDUop))
            MDU_MULT, MDU_MULTU: begin
              accept  = 1'b1;
              cnt_d   = CNT_W'(MULT_LAT);
              state_d = RUN;
            end
            MDU_DIV, MDU_DIVU: begin
              accept  = 1'b1;
              cnt_d   = CNT_W'(DIV_LAT);
              state_d = RUN;
            end
            MDU_MTHI: mt_hi = 1'b1;
            MDU_MTLO: mt_lo = 1'b1;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(1)) begin
          commit  = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      HI      <= '0;
      LO      <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= commit;
      if (accept) begin
        pend_hi <= calc_hi;
        pend_lo <= calc_lo;
      end
      if (commit) begin
        HI <= pend_hi;
        LO <= pend_lo;
      end else begin
        if (mt_hi) HI <= SrcA;
        if (mt_lo) LO <= SrcA;
      end
    end
  end

  assign Busy      = (state_q == RUN);
  assign Done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo: arithmetic results, latency,
// Done pulse, ignored requests, reserved ops, reset abort and back-to-back issue.
module tb_mdu_hilo;
  import mdu_defs::*;

  logic        clk;
  logic        reset_n;
  logic        Start;
  logic [2:0]  MDUop;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Done;
  logic [31:0] HI;
  logic [31:0] LO;
  mdu_state_e  dbg_state;

  int checks = 0;
  int errors = 0;

  mdu_hilo #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Start     (Start),
    .MDUop     (MDUop),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .Busy      (Busy),
    .Done      (Done),
    .HI        (HI),
    .LO        (LO),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; inputs are sampled at the next posedge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1;
    MDUop = op;
    SrcA  = a;
    SrcB  = b;
    @(negedge clk);
    Start = 1'b0;
    MDUop = 3'd0;
    SrcA  = 32'd0;
    SrcB  = 32'd0;
  endtask

  // Issue, count Busy cycles with HI/LO held, then check the commit cycle.
  // With keep=1 the task returns in the Done cycle without advancing.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input int exp_lat, input bit keep);
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    int n;
    bit stable;
    old_hi = HI;
    old_lo = LO;
    n = 0;
    stable = 1'b1;
    issue(op, a, b);
    while (Busy === 1'b1 && n < 200) begin
      n++;
      if (HI !== old_hi || LO !== old_lo || Done !== 1'b0) stable = 1'b0;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_lat));
    check({tag, "_stable"}, {31'd0, stable}, 32'd1);
    check({tag, "_done"}, {31'd0, Done}, 32'd1);
    check({tag, "_hi"}, HI, exp_hi);
    check({tag, "_lo"}, LO, exp_lo);
    if (!keep) begin
      @(negedge clk);
      check({tag, "_done_fall"}, {31'd0, Done}, 32'd0);
    end
  endtask

  initial begin : stim
    int n;
    int pulses;
    Start   = 1'b0;
    MDUop   = 3'd0;
    SrcA    = 32'd0;
    SrcB    = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd0);
    check("rst_done", {31'd0, Done}, 32'd0);

    run_op("mult",     3'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 5, 1'b0);
    run_op("multu",    3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 5, 1'b0);
    run_op("divu",     3'd3, 32'd7, 32'd2, 32'd1, 32'd3, 10, 1'b0);
    run_op("div_neg",  3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
    run_op("div_ovf",  3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0);
    run_op("divu_z",   3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 10, 1'b0);
    run_op("div_z",    3'd2, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 10, 1'b0);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 5, 1'b0);

    // MTHI while idle: visible next cycle, no Busy, no Done.
    issue(3'd4, 32'h1234_5678, 32'd0);
    check("mthi_hi", HI, 32'h1234_5678);
    check("mthi_lo", LO, 32'd15);
    check("mthi_busy", {31'd0, Busy}, 32'd0);
    check("mthi_done", {31'd0, Done}, 32'd0);
    issue(3'd5, 32'hCAFE_0001, 32'd0);
    check("mtlo_lo", LO, 32'hCAFE_0001);
    check("mtlo_hi", HI, 32'h1234_5678);

    // MTLO and a second MULT while busy are dropped.
    issue(3'd0, 32'd3, 32'd4);
    check("inflight_busy", {31'd0, Busy}, 32'd1);
    check("inflight_state", {31'd0, dbg_state}, 32'd1);
    issue(3'd5, 32'hDEAD_BEEF, 32'd0);
    issue(3'd0, 32'd100, 32'd100);
    check("inflight_lo_held", LO, 32'hCAFE_0001);
    n = 0;
    while (Busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("ign_busy_rest", 32'(n), 32'd3);
    check("ign_done", {31'd0, Done}, 32'd1);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd12);
    @(negedge clk);
    check("ign_no_second", {31'd0, Busy}, 32'd0);
    check("ign_lo_kept", LO, 32'd12);

    // Reserved op 6 leaves everything untouched.
    issue(3'd6, 32'hAAAA_AAAA, 32'h5555_5555);
    check("rsv_busy", {31'd0, Busy}, 32'd0);
    check("rsv_done", {31'd0, Done}, 32'd0);
    check("rsv_hi", HI, 32'd0);
    check("rsv_lo", LO, 32'd12);
    issue(3'd7, 32'hAAAA_AAAA, 32'h5555_5555);
    check("rsv7_busy", {31'd0, Busy}, 32'd0);
    check("rsv7_lo", LO, 32'd12);

    // Back-to-back: second MULT issued in the Done cycle.
    run_op("b2b_first",  3'd1, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5, 1'b1);
    run_op("b2b_second", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0);

    // Reset on the 3rd busy cycle aborts the MULT.
    issue(3'd0, 32'd9, 32'd9);
    @(negedge clk);
    @(negedge clk);
    check("abort_busy_pre", {31'd0, Busy}, 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort_hi", HI, 32'd0);
    check("abort_lo", LO, 32'd0);
    check("abort_busy", {31'd0, Busy}, 32'd0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      if (Done === 1'b1) pulses++;
      if (Busy === 1'b1) pulses++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(pulses), 32'd0);
    check("abort_lo_after", LO, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
